// File: rtl/fpu_arith_pkg.sv
// Shared constants and helpers for the floating-point datapath arithmetic blocks.
package fpu_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int CLA_GRP = 4;

  // Bits resolved by each pipeline stage.
  function automatic int stage_bits(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined add/sub block.
interface cla_addsub_pipe_if #(parameter int WIDTH = 32);
  import fpu_arith_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op_sub, a, b, ci, out_ready,
    input  in_ready, out_valid, result, co, ovf, zero
  );

  modport slave (
    input  in_valid, op_sub, a, b, ci, out_ready,
    output in_ready, out_valid, result, co, ovf, zero
  );

endinterface

// File: rtl/cla_addsub_pipe_cla4_group.sv
// 4-bit carry-look-ahead slice: fully flattened internal carries plus group G/P.
module cla4_group
  import fpu_arith_pkg::*;
(
  input  logic [CLA_GRP-1:0] x,
  input  logic [CLA_GRP-1:0] y,
  input  logic               c_in,
  output logic [CLA_GRP-1:0] sum,
  output logic               G,
  output logic               P
);

  logic [CLA_GRP-1:0] gen;
  logic [CLA_GRP-1:0] prop;
  logic [CLA_GRP-1:0] c;

  assign gen  = x & y;
  assign prop = x ^ y;

  assign c[0] = c_in;
  assign c[1] = gen[0] | (prop[0] & c_in);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c_in);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & c_in);

  assign sum = prop ^ c;

  assign G = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign P = &prop;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor: one S-bit slice per stage, carry registered between
// stages, operands skewed forward and finished slices carried along so results align.
module cla_addsub_pipe
  import fpu_arith_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  cla_addsub_pipe_if.slave bus
);

  localparam int S  = stage_bits(WIDTH, STAGES);
  localparam int NG = S / CLA_GRP;

  if (STAGES < 1 || STAGES > WIDTH / CLA_GRP || (WIDTH % (CLA_GRP * STAGES)) != 0) begin : g_bad_cfg
    $error("cla_addsub_pipe: WIDTH must be a multiple of 4*STAGES with 1 <= STAGES <= WIDTH/4");
  end

  logic             adv;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             co_q;
  logic             ovf_q;
  logic             zero_q;

  // Whole pipeline moves together; it only freezes while a finished beat is refused.
  assign adv           = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int WA = WIDTH - k * S;

    logic             v_i;
    logic             sub_i;
    logic             c_i;
    logic [WA-1:0]    a_i;
    logic [WA-1:0]    b_i;
    logic [(k+1)*S-1:0] r_n;
    logic [S-1:0]     x;
    logic [S-1:0]     y;
    logic [S-1:0]     sum;
    logic [NG:0]      gc;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;

    if (k == 0) begin : g_head
      assign v_i   = bus.in_valid;
      assign sub_i = bus.op_sub;
      assign c_i   = (bus.op_sub == OP_SUB) ? ~bus.ci : bus.ci;
      assign a_i   = bus.a;
      assign b_i   = bus.b;
      assign r_n   = sum;
    end else begin : g_body
      assign v_i   = g_stage[k-1].g_fwd.v_q;
      assign sub_i = g_stage[k-1].g_fwd.sub_q;
      assign c_i   = g_stage[k-1].g_fwd.c_q;
      assign a_i   = g_stage[k-1].g_fwd.a_q;
      assign b_i   = g_stage[k-1].g_fwd.b_q;
      assign r_n   = {sum, g_stage[k-1].g_fwd.r_q};
    end

    assign x = a_i[S-1:0];
    assign y = (sub_i == OP_SUB) ? ~b_i[S-1:0] : b_i[S-1:0];

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla4_group u_grp (
        .x    (x[j*CLA_GRP +: CLA_GRP]),
        .y    (y[j*CLA_GRP +: CLA_GRP]),
        .c_in (gc[j]),
        .sum  (sum[j*CLA_GRP +: CLA_GRP]),
        .G    (gg[j]),
        .P    (gp[j])
      );
    end

    // Second-level look-ahead: each group carry as a sum of products of group G/P.
    always_comb begin : p_lookahead
      logic term;
      logic pall;
      term  = 1'b0;
      pall  = 1'b1;
      gc    = '0;
      gc[0] = c_i;
      for (int j = 1; j <= NG; j++) begin
        term = 1'b0;
        pall = 1'b1;
        for (int i = j - 1; i >= 0; i--) begin
          term = term | (pall & gg[i]);
          pall = pall & gp[i];
        end
        gc[j] = term | (pall & c_i);
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic                v_q;
      logic                sub_q;
      logic                c_q;
      logic [WA-S-1:0]     a_q;
      logic [WA-S-1:0]     b_q;
      logic [(k+1)*S-1:0]  r_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          sub_q <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          r_q   <= '0;
        end else if (adv) begin
          v_q   <= v_i;
          sub_q <= sub_i;
          c_q   <= gc[NG];
          a_q   <= a_i[WA-1:S];
          b_q   <= b_i[WA-1:S];
          r_q   <= r_n;
        end
      end
    end else begin : g_tail
      logic cin_msb;

      // Carry into the MSB recovered from its sum bit and operand bits.
      assign cin_msb = sum[S-1] ^ x[S-1] ^ y[S-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          result_q    <= '0;
          co_q        <= 1'b0;
          ovf_q       <= 1'b0;
          zero_q      <= 1'b0;
        end else if (adv) begin
          out_valid_q <= v_i;
          result_q    <= r_n;
          co_q        <= (sub_i == OP_SUB) ? ~gc[NG] : gc[NG];
          ovf_q       <= cin_msb ^ gc[NG];
          zero_q      <= (r_n == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: arithmetic reference model with a result queue,
// directed corner beats, backpressure, random traffic and mid-flight reset.
module tb_cla_addsub_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             co;
    logic             ovf;
    logic             zero;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cla_addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

  cla_addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  bit   rand_ready = 1'b0;
  bit   ready_cmd  = 1'b1;
  bit   rr         = 1'b1;
  bit   seen;
  logic [35:0] hold;

  assign bus.out_ready = rand_ready ? rr : ready_cmd;

  always @(posedge clk) begin
    #1;
    rr = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then wrap/flag extraction.
  function automatic res_t model(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci);
    res_t   m;
    longint u;
    longint s;
    if (op) begin
      u    = longint'(a) - longint'(b) - longint'(ci);
      s    = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
      m.co = (u < 0);
    end else begin
      u    = longint'(a) + longint'(b) + longint'(ci);
      s    = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
      m.co = (u >= 64'sh1_0000_0000);
    end
    m.r    = u[WIDTH-1:0];
    m.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    m.zero = (m.r == '0);
    return m;
  endfunction

  // Single compare process: every valid output must match the oldest outstanding beat.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", bus.out_valid, 1'b0);
        end else begin
          chk("stream_out", {bus.result, bus.co, bus.ovf, bus.zero}, exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.op_sub, bus.a, bus.b, bus.ci));
    end
  end

  task automatic drive_beat(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic ci);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.op_sub   = op;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500; n++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  // Directed beat: pins the model to literals and checks latency and outputs on the DUT.
  task automatic dir(input string nm, input logic op, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic ci, input res_t want);
    res_t m;
    m = model(op, a, b, ci);
    chk({nm, "_model"}, m, want);
    drive_beat(op, a, b, ci);
    chk({nm, "_early"}, bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk({nm, "_latency"}, bus.out_valid, 1'b1);
    chk({nm, "_out"}, {bus.result, bus.co, bus.ovf, bus.zero}, want);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.op_sub   = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.ci       = 1'b0;
    ready_cmd    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.out_valid, bus.result, bus.co, bus.ovf, bus.zero}, 36'h0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    dir("add_wrap",     1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1});
    dir("add_boundary", 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, '{32'h0001_0000, 1'b0, 1'b0, 1'b0});
    dir("sub_borrow",   1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
    dir("sub_bin",      1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, '{32'h0000_0001, 1'b0, 1'b0, 1'b0});
    dir("sub_ovf",      1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    dir("add_ovf",      1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0});

    // Backpressure: six back-to-back beats, consumer refuses the first result for 3 cycles.
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive_beat(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      begin
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
          @(posedge clk);
          #1;
          if (bus.out_valid) seen = 1'b1;
        end
        chk("bp_first_result", bus.out_valid, 1'b1);
        ready_cmd = 1'b0;
        hold = {bus.out_valid, bus.result, bus.co, bus.ovf, bus.zero};
        for (int c = 0; c < 3; c++) begin
          #1;
          chk("bp_in_ready_low", bus.in_ready, 1'b0);
          @(posedge clk);
          #1;
          chk("bp_hold_stable", {bus.out_valid, bus.result, bus.co, bus.ovf, bus.zero}, hold);
        end
        ready_cmd = 1'b1;
      end
    join
    wait_drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      drive_beat(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    ready_cmd  = 1'b1;
    wait_drain();

    // Reset with two beats in flight, between clock edges.
    drive_beat(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    drive_beat(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);
    chk("rst_pre_inflight", bus.out_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {bus.out_valid, bus.result, bus.co, bus.ovf, bus.zero}, 36'h0);
    chk("rst_async_in_ready", bus.in_ready, 1'b1);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("rst_no_stale", bus.out_valid, 1'b0);
    end
    dir("post_reset", 1'b0, 32'h0000_0003, 32'h0000_0004, 1'b1, '{32'h0000_0008, 1'b0, 1'b0, 1'b0});
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
